// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants for the timing generator,
// the sprite mappers and the top level.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 10;

    // hs/vs are active-low on the VGA connector
    localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-scan bundle: the generator drives the raster position and syncs,
// consumers may drive anim_hold back.
interface vga_timing_gen_if #(
    parameter int ANIM_W = 2
);
    import vga_pkg::*;

    logic              anim_hold;
    logic [CNT_W-1:0]  DrawX;
    logic [CNT_W-1:0]  DrawY;
    logic              blank;
    logic              hs;
    logic              vs;
    logic              line_start;
    logic              frame_start;
    logic [ANIM_W-1:0] anim_frame;

    modport master (
        input  anim_hold,
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, anim_frame
    );

    modport slave (
        output anim_hold,
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, anim_frame
    );

endinterface

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register used to align decoded video controls
// with the mapper pipeline; DEPTH 0 is a plain wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank decode with pipeline alignment, and the
// sprite animation frame counter.
module vga_timing_gen #(
    parameter int H_VIS       = vga_pkg::H_VIS,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_VIS       = vga_pkg::V_VIS,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int BLANK_DLY   = 1,
    parameter int SYNC_DLY    = 2,
    parameter int ANIM_DIV    = 8,
    parameter int ANIM_FRAMES = 4
) (
    input  logic vga_clk,
    input  logic reset,
    vga_timing_gen_if.master bus
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int ANIM_W  = $clog2(ANIM_FRAMES);
    localparam int FC_W    = $clog2(ANIM_DIV + 1);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(ANIM_DIV - 1);
    localparam logic [ANIM_W-1:0] AF_LAST  = ANIM_W'(ANIM_FRAMES - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
        end
        if (BLANK_DLY < 0 || BLANK_DLY > 4 || SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_bad_dly
            $error("vga_timing_gen: BLANK_DLY/SYNC_DLY must be 0..4");
        end
        if (ANIM_DIV < 1 || ANIM_FRAMES < 2) begin : g_bad_anim
            $error("vga_timing_gen: ANIM_DIV >= 1 and ANIM_FRAMES >= 2 required");
        end
    endgenerate

    logic [CNT_W-1:0]  hc;
    logic [CNT_W-1:0]  vc;
    logic [FC_W-1:0]   frame_cnt;
    logic [ANIM_W-1:0] anim_frame_q;
    logic              h_end;
    logic              v_end;

    assign h_end = (hc == H_LAST);
    assign v_end = (vc == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc           <= '0;
            vc           <= '0;
            frame_cnt    <= '0;
            anim_frame_q <= '0;
        end else begin
            if (h_end) begin
                hc <= '0;
                vc <= v_end ? '0 : vc + CNT_W'(1);
            end else begin
                hc <= hc + CNT_W'(1);
            end

            // animation advances at the last pixel so the new index lands with frame_start
            if (h_end && v_end && !bus.anim_hold) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt    <= '0;
                    anim_frame_q <= (anim_frame_q == AF_LAST) ? '0 : anim_frame_q + ANIM_W'(1);
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
            end
        end
    end

    // raw decode from the current raster position
    logic       blank_raw;
    logic [1:0] sync_raw;
    logic [1:0] sync_q;
    logic       blank_q;

    assign blank_raw   = (hc < CNT_W'(H_VIS)) && (vc < CNT_W'(V_VIS));
    assign sync_raw[1] = (hc >= HS_START && hc < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign sync_raw[0] = (vc >= VS_START && vc < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    vga_delay_line #(
        .WIDTH     (1),
        .DEPTH     (BLANK_DLY),
        .RESET_VAL (1'b0)
    ) u_blank_dly (
        .clk (vga_clk),
        .rst (reset),
        .d   (blank_raw),
        .q   (blank_q)
    );

    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (SYNC_DLY),
        .RESET_VAL ({2{~SYNC_ACTIVE}})
    ) u_sync_dly (
        .clk (vga_clk),
        .rst (reset),
        .d   (sync_raw),
        .q   (sync_q)
    );

    assign bus.DrawX       = hc;
    assign bus.DrawY       = vc;
    assign bus.blank       = blank_q;
    assign bus.hs          = sync_q[1];
    assign bus.vs          = sync_q[0];
    assign bus.line_start  = (hc == '0);
    assign bus.frame_start = (hc == '0) && (vc == '0);
    assign bus.anim_frame  = anim_frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-raster instance for whole-frame and
// animation behaviour plus a default 640x480 instance for the real timing.
module tb_vga_timing_gen;

    typedef struct packed {
        int hv, hfp, hsy, hbp, vv, vfp, vsy, vbp;
    } tim_t;

    localparam tim_t ST = '{16, 2, 4, 3, 12, 2, 2, 3};
    localparam tim_t DT = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam int S_HT = 25;
    localparam int S_VT = 19;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int DIV = 8;
    localparam int NFR = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.ANIM_W(2)) bus_s ();
    vga_timing_gen_if #(.ANIM_W(2)) bus_d ();

    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .BLANK_DLY(1), .SYNC_DLY(2), .ANIM_DIV(DIV), .ANIM_FRAMES(NFR)
    ) dut_s (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus_s)
    );

    vga_timing_gen dut_d (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus_d)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;
    int counted = 0;
    bit hold = 1'b0;
    int fs_cnt, ls_cnt, chg_cnt;
    logic [1:0] prev_anim = '0;

    function automatic int htot(tim_t t);
        return t.hv + t.hfp + t.hsy + t.hbp;
    endfunction

    function automatic int vtot(tim_t t);
        return t.vv + t.vfp + t.vsy + t.vbp;
    endfunction

    function automatic int hpos(tim_t t, int n);
        return n % htot(t);
    endfunction

    function automatic int vpos(tim_t t, int n);
        return (n / htot(t)) % vtot(t);
    endfunction

    // expected outputs d clocks after the raster was at position n-d
    function automatic bit exp_blank(tim_t t, int n, int d);
        if (n < d) return 1'b0;
        return (hpos(t, n - d) < t.hv) && (vpos(t, n - d) < t.vv);
    endfunction

    function automatic bit exp_hs(tim_t t, int n, int d);
        int h;
        if (n < d) return 1'b1;
        h = hpos(t, n - d);
        return !(h >= t.hv + t.hfp && h < t.hv + t.hfp + t.hsy);
    endfunction

    function automatic bit exp_vs(tim_t t, int n, int d);
        int v;
        if (n < d) return 1'b1;
        v = vpos(t, n - d);
        return !(v >= t.vv + t.vfp && v < t.vv + t.vfp + t.vsy);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s_drawx", 32'(bus_s.DrawX), hpos(ST, k));
        chk("s_drawy", 32'(bus_s.DrawY), vpos(ST, k));
        chk("s_blank", 32'(bus_s.blank), 32'(exp_blank(ST, k, 1)));
        chk("s_hs", 32'(bus_s.hs), 32'(exp_hs(ST, k, 2)));
        chk("s_vs", 32'(bus_s.vs), 32'(exp_vs(ST, k, 2)));
        chk("s_line_start", 32'(bus_s.line_start), 32'(hpos(ST, k) == 0));
        chk("s_frame_start", 32'(bus_s.frame_start), 32'(k % S_FRAME == 0));
        chk("s_anim_frame", 32'(bus_s.anim_frame), (counted / DIV) % NFR);
        chk("d_drawx", 32'(bus_d.DrawX), hpos(DT, k));
        chk("d_drawy", 32'(bus_d.DrawY), vpos(DT, k));
        chk("d_blank", 32'(bus_d.blank), 32'(exp_blank(DT, k, 1)));
        chk("d_hs", 32'(bus_d.hs), 32'(exp_hs(DT, k, 2)));
        chk("d_vs", 32'(bus_d.vs), 32'(exp_vs(DT, k, 2)));
        chk("d_anim_frame", 32'(bus_d.anim_frame), 0);
        if (bus_s.anim_frame !== prev_anim) begin
            chg_cnt++;
            chk("anim_change_at_frame_start", 32'(bus_s.frame_start), 1);
        end
        prev_anim = bus_s.anim_frame;
        if (bus_s.frame_start === 1'b1) fs_cnt++;
        if (bus_s.line_start === 1'b1) ls_cnt++;
    endtask

    task automatic tick();
        bus_s.anim_hold = hold;
        bus_d.anim_hold = hold;
        @(posedge clk);
        if (reset) begin
            k = 0;
            counted = 0;
        end else begin
            if (hpos(ST, k) == S_HT - 1 && vpos(ST, k) == S_VT - 1 && !hold) counted++;
            k++;
        end
        #1;
        check_all();
    endtask

    initial begin
        bit found;
        int run_len;
        bus_s.anim_hold = 1'b0;
        bus_d.anim_hold = 1'b0;

        // reset state: counters at 0, syncs inactive, start pulses high
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_blank", 32'(bus_s.blank), 0);
        chk("rst_hs", 32'(bus_d.hs), 1);
        chk("rst_frame_start", 32'(bus_s.frame_start), 1);

        // free run for 33 frames, counting pulses and animation steps
        reset = 1'b0;
        fs_cnt = 0;
        ls_cnt = 0;
        chg_cnt = 0;
        run_len = 33 * S_FRAME + 10;
        repeat (run_len) tick();
        chk("frame_start_count", fs_cnt, run_len / S_FRAME);
        chk("line_start_count", ls_cnt, run_len / S_HT);
        chk("anim_changes_33_frames", chg_cnt, 4);

        // hold animation during frames 3..20
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int f = 0; f < 30; f++) begin
            hold = (f >= 3 && f <= 20);
            repeat (S_FRAME) tick();
        end
        chk("anim_after_hold", 32'(bus_s.anim_frame), 1);
        hold = 1'b0;

        // random hold toggling
        for (int i = 0; i < 20 * S_FRAME; i++) begin
            if ($urandom_range(0, 299) == 0) hold = ~hold;
            tick();
        end
        hold = 1'b0;

        // reset mid-frame and restart from (0,0)
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            if (bus_s.DrawX == 10'd10 && bus_s.DrawY == 10'd5) found = 1'b1;
            else tick();
        end
        chk("reach_mid_frame", 32'(found), 1);
        reset = 1'b1;
        repeat (3) tick();
        chk("midrst_blank", 32'(bus_s.blank), 0);
        chk("midrst_vs", 32'(bus_s.vs), 1);
        chk("midrst_anim", 32'(bus_s.anim_frame), 0);
        reset = 1'b0;
        repeat (3 * S_FRAME) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
